// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: opcodes, ALU op encodings and
// the layout of the decoder control bundle carried down the pipe.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [2:0] ALU_OP_R   = 3'b100;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam logic [2:0] ALU_OP_SUB = 3'b110;
  localparam logic [2:0] ALU_OP_SLT = 3'b111;

  localparam int CTRL_W = 13;

  // Bit offsets inside the packed bundle below (bit 0 is RegWrite).
  localparam int CTL_REGWRITE = 0;
  localparam int CTL_ALUSRC   = 1;
  localparam int CTL_REGDST   = 2;
  localparam int CTL_BRANCH   = 3;
  localparam int CTL_JUMP     = 4;
  localparam int CTL_MEMREAD  = 5;
  localparam int CTL_MEMWRITE = 6;
  localparam int CTL_MEMTOREG = 7;
  localparam int CTL_JAL      = 8;
  localparam int CTL_RTYPE    = 9;
  localparam int CTL_ALUOP_LO = 10;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       rtype;
    logic       jal;
    logic       memtoreg;
    logic       memwrite;
    logic       memread;
    logic       jump;
    logic       branch;
    logic       regdst;
    logic       alusrc;
    logic       regwrite;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: flags an ID instruction that reads the register a
// load currently in EX is about to write.
module load_use_detect
  import mips_pkg::*;
#(
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_rtype_i,
  input  logic       id_branch_i,
  input  logic       id_memwrite_i,
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  output logic       uses_rt_o,
  output logic       hazard_o
);

  logic rs_match;
  logic rt_match;

  assign uses_rt_o = id_rtype_i | id_branch_i | id_memwrite_i;
  assign rs_match  = (ex_rt_i == id_rs_i);
  assign rt_match  = uses_rt_o & (ex_rt_i == id_rt_i);

  // $0 is hard-wired zero, so a load targeting it never produces a dependency.
  assign hazard_o = HAZARD_EN & id_valid_i & ex_valid_i & ex_memread_i &
                    (ex_rt_i != 5'd0) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: latches decoder controls, register fields and operands,
// inserts a bubble on flush, load-use hazard or empty ID, and counts stall cycles.
module id_ex_stage_reg
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [31:0]       instr_i,
  input  logic              RegWrite_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic              Branch_i,
  input  logic              Jump_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  input  logic              Jal_i,
  input  logic              Rtype_i,
  input  logic [2:0]        ALU_op_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] se_imm_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic              ex_RegWrite_o,
  output logic              ex_ALUSrc_o,
  output logic              ex_RegDst_o,
  output logic              ex_Branch_o,
  output logic              ex_Jump_o,
  output logic              ex_MemRead_o,
  output logic              ex_MemWrite_o,
  output logic              ex_MemtoReg_o,
  output logic              ex_Jal_o,
  output logic              ex_Rtype_o,
  output logic [2:0]        ex_ALU_op_o,
  output logic [4:0]        ex_rs_o,
  output logic [4:0]        ex_rt_o,
  output logic [4:0]        ex_rd_o,
  output logic [5:0]        ex_funct_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  ctrl_t              id_ctrl;
  ctrl_t              ctrl_d, ctrl_q;
  logic               valid_d, valid_q;
  logic [4:0]         rs_q, rt_q, rd_q;
  logic [5:0]         funct_q;
  logic [DATA_W-1:0]  rs_data_q, rt_data_q, imm_q, pc4_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               hazard;
  logic               uses_rt;
  logic               unused_instr_bits;

  assign id_ctrl = '{alu_op:   ALU_op_i,
                     rtype:    Rtype_i,
                     jal:      Jal_i,
                     memtoreg: MemtoReg_i,
                     memwrite: MemWrite_i,
                     memread:  MemRead_i,
                     jump:     Jump_i,
                     branch:   Branch_i,
                     regdst:   RegDst_i,
                     alusrc:   ALUSrc_i,
                     regwrite: RegWrite_i};

  // Opcode and shamt are already decoded upstream; EX does not need them.
  assign unused_instr_bits = ^{instr_i[31:26], instr_i[10:6], uses_rt};

  load_use_detect #(
    .HAZARD_EN (HAZARD_EN)
  ) u_load_use_detect (
    .id_valid_i    (id_valid_i),
    .id_rs_i       (instr_i[25:21]),
    .id_rt_i       (instr_i[20:16]),
    .id_rtype_i    (Rtype_i),
    .id_branch_i   (Branch_i),
    .id_memwrite_i (MemWrite_i),
    .ex_valid_i    (valid_q),
    .ex_memread_i  (ctrl_q.memread),
    .ex_rt_i       (rt_q),
    .uses_rt_o     (uses_rt),
    .hazard_o      (hazard)
  );

  // A flushed instruction is dead, so it must not hold the front end.
  assign stall_o = hazard & ~flush_i;

  always_comb begin
    ctrl_d  = '0;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (!flush_i && !hazard && id_valid_i) begin
      ctrl_d  = id_ctrl;
      valid_d = 1'b1;
    end
    if (stall_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc4_q     <= '0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      // Fields and operands load even on a bubble; EX ignores them when invalid.
      rs_q      <= instr_i[25:21];
      rt_q      <= instr_i[20:16];
      rd_q      <= instr_i[15:11];
      funct_q   <= instr_i[5:0];
      rs_data_q <= rs_data_i;
      rt_data_q <= rt_data_i;
      imm_q     <= se_imm_i;
      pc4_q     <= pc4_i;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_RegWrite_o = ctrl_q.regwrite;
  assign ex_ALUSrc_o   = ctrl_q.alusrc;
  assign ex_RegDst_o   = ctrl_q.regdst;
  assign ex_Branch_o   = ctrl_q.branch;
  assign ex_Jump_o     = ctrl_q.jump;
  assign ex_MemRead_o  = ctrl_q.memread;
  assign ex_MemWrite_o = ctrl_q.memwrite;
  assign ex_MemtoReg_o = ctrl_q.memtoreg;
  assign ex_Jal_o      = ctrl_q.jal;
  assign ex_Rtype_o    = ctrl_q.rtype;
  assign ex_ALU_op_o   = ctrl_q.alu_op;
  assign ex_rs_o       = rs_q;
  assign ex_rt_o       = rt_q;
  assign ex_rd_o       = rd_q;
  assign ex_funct_o    = funct_q;
  assign ex_rs_data_o  = rs_data_q;
  assign ex_rt_data_o  = rt_data_q;
  assign ex_imm_o      = imm_q;
  assign ex_pc4_o      = pc4_q;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: vector table for single-cycle behaviour plus
// sequences for reset mid-stall and counter saturation.
module tb_id_ex_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        id_valid_i, flush_i;
  logic [31:0] instr_i;
  logic        RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, Jump_i;
  logic        MemRead_i, MemWrite_i, MemtoReg_i, Jal_i, Rtype_i;
  logic [2:0]  ALU_op_i;
  logic [31:0] rs_data_i, rt_data_i, se_imm_i, pc4_i;

  // main instance outputs
  logic        ex_valid_o, ex_RegWrite_o, ex_ALUSrc_o, ex_RegDst_o, ex_Branch_o, ex_Jump_o;
  logic        ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o, ex_Jal_o, ex_Rtype_o, stall_o;
  logic [2:0]  ex_ALU_op_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic [5:0]  ex_funct_o;
  logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o;
  logic [15:0] stall_cnt_o;

  // CNT_W=2 instance outputs
  logic        s_valid, s_rw, s_as, s_rdst, s_br, s_jmp, s_mr, s_mw, s_m2r, s_jal, s_rt_ty, s_stall;
  logic [2:0]  s_aluop;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [5:0]  s_funct;
  logic [31:0] s_rsd, s_rtd, s_imm, s_pc4;
  logic [1:0]  s_cnt;

  // HAZARD_EN=0 instance outputs
  logic        n_valid, n_rw, n_as, n_rdst, n_br, n_jmp, n_mr, n_mw, n_m2r, n_jal, n_rt_ty, n_stall;
  logic [2:0]  n_aluop;
  logic [4:0]  n_rs, n_rt, n_rd;
  logic [5:0]  n_funct;
  logic [31:0] n_rsd, n_rtd, n_imm, n_pc4;
  logic [15:0] n_cnt;

  int checks = 0;
  int errors = 0;
  int seq_n  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  id_ex_stage_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .instr_i(instr_i),
    .RegWrite_i(RegWrite_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .Branch_i(Branch_i),
    .Jump_i(Jump_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i),
    .Jal_i(Jal_i), .Rtype_i(Rtype_i), .ALU_op_i(ALU_op_i), .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i), .se_imm_i(se_imm_i), .pc4_i(pc4_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_RegWrite_o(ex_RegWrite_o), .ex_ALUSrc_o(ex_ALUSrc_o),
    .ex_RegDst_o(ex_RegDst_o), .ex_Branch_o(ex_Branch_o), .ex_Jump_o(ex_Jump_o),
    .ex_MemRead_o(ex_MemRead_o), .ex_MemWrite_o(ex_MemWrite_o), .ex_MemtoReg_o(ex_MemtoReg_o),
    .ex_Jal_o(ex_Jal_o), .ex_Rtype_o(ex_Rtype_o), .ex_ALU_op_o(ex_ALU_op_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o),
    .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
    .ex_pc4_o(ex_pc4_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  id_ex_stage_reg #(.DATA_W(32), .CNT_W(2), .HAZARD_EN(1'b1)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .instr_i(instr_i),
    .RegWrite_i(RegWrite_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .Branch_i(Branch_i),
    .Jump_i(Jump_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i),
    .Jal_i(Jal_i), .Rtype_i(Rtype_i), .ALU_op_i(ALU_op_i), .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i), .se_imm_i(se_imm_i), .pc4_i(pc4_i), .flush_i(flush_i),
    .ex_valid_o(s_valid), .ex_RegWrite_o(s_rw), .ex_ALUSrc_o(s_as), .ex_RegDst_o(s_rdst),
    .ex_Branch_o(s_br), .ex_Jump_o(s_jmp), .ex_MemRead_o(s_mr), .ex_MemWrite_o(s_mw),
    .ex_MemtoReg_o(s_m2r), .ex_Jal_o(s_jal), .ex_Rtype_o(s_rt_ty), .ex_ALU_op_o(s_aluop),
    .ex_rs_o(s_rs), .ex_rt_o(s_rt), .ex_rd_o(s_rd), .ex_funct_o(s_funct),
    .ex_rs_data_o(s_rsd), .ex_rt_data_o(s_rtd), .ex_imm_o(s_imm), .ex_pc4_o(s_pc4),
    .stall_o(s_stall), .stall_cnt_o(s_cnt)
  );

  id_ex_stage_reg #(.DATA_W(32), .CNT_W(16), .HAZARD_EN(1'b0)) dut_nohz (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .instr_i(instr_i),
    .RegWrite_i(RegWrite_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .Branch_i(Branch_i),
    .Jump_i(Jump_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i),
    .Jal_i(Jal_i), .Rtype_i(Rtype_i), .ALU_op_i(ALU_op_i), .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i), .se_imm_i(se_imm_i), .pc4_i(pc4_i), .flush_i(flush_i),
    .ex_valid_o(n_valid), .ex_RegWrite_o(n_rw), .ex_ALUSrc_o(n_as), .ex_RegDst_o(n_rdst),
    .ex_Branch_o(n_br), .ex_Jump_o(n_jmp), .ex_MemRead_o(n_mr), .ex_MemWrite_o(n_mw),
    .ex_MemtoReg_o(n_m2r), .ex_Jal_o(n_jal), .ex_Rtype_o(n_rt_ty), .ex_ALU_op_o(n_aluop),
    .ex_rs_o(n_rs), .ex_rt_o(n_rt), .ex_rd_o(n_rd), .ex_funct_o(n_funct),
    .ex_rs_data_o(n_rsd), .ex_rt_data_o(n_rtd), .ex_imm_o(n_imm), .ex_pc4_o(n_pc4),
    .stall_o(n_stall), .stall_cnt_o(n_cnt)
  );

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd);
    r_ins = {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    i_ins = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Drives the decoder controls a real MIPS decoder would produce for the opcode.
  task automatic drive(input logic vld, input logic [31:0] ins, input logic fl);
    logic [5:0] op;
    op = ins[31:26];
    id_valid_i = vld; instr_i = ins; flush_i = fl;
    {RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, Jump_i} = '0;
    {MemRead_i, MemWrite_i, MemtoReg_i, Jal_i, Rtype_i} = '0;
    ALU_op_i = 3'b000;
    case (op)
      6'd0:  begin RegWrite_i = 1; RegDst_i = 1; Rtype_i = 1; ALU_op_i = 3'b100; end
      6'd35: begin RegWrite_i = 1; ALUSrc_i = 1; MemRead_i = 1; MemtoReg_i = 1; ALU_op_i = 3'b010; end
      6'd43: begin ALUSrc_i = 1; MemWrite_i = 1; ALU_op_i = 3'b010; end
      6'd8:  begin RegWrite_i = 1; ALUSrc_i = 1; ALU_op_i = 3'b010; end
      6'd4:  begin Branch_i = 1; ALU_op_i = 3'b110; end
      default: ;
    endcase
    seq_n     = seq_n + 1;
    rs_data_i = 32'hA000_0000 + seq_n;
    rt_data_i = 32'hB000_0000 + seq_n;
    se_imm_i  = {{16{ins[15]}}, ins[15:0]};
    pc4_i     = 32'h0040_0000 + 4 * seq_n;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] ins;
    logic        fl;
    logic        e_stall;
    logic        e_valid;
    logic        e_rw;
    logic        e_mr;
    logic [2:0]  e_aluop;
    logic [4:0]  e_rd;
    logic [4:0]  e_rt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] ADD3, LW4, ADD5_46, LW0, ADD5_06, SW4, ADD5_64, ADDI4;
  logic [31:0] exp_rsd;
  logic [15:0] sat_exp;

  initial begin
    ADD3    = r_ins(1, 2, 3);
    LW4     = i_ins(35, 1, 4, 0);
    ADD5_46 = r_ins(4, 6, 5);
    LW0     = i_ins(35, 1, 0, 0);
    ADD5_06 = r_ins(0, 6, 5);
    SW4     = i_ins(43, 7, 4, 0);
    ADD5_64 = r_ins(6, 4, 5);
    ADDI4   = i_ins(8, 1, 4, 5);

    //            vld ins      fl  stall v  rw mr aluop   rd    rt    cnt
    vecs.push_back('{1, ADD3,    0, 0, 1, 1, 0, 3'b100, 5'd3, 5'd2, 16'd0});
    vecs.push_back('{0, 32'd0,   0, 0, 0, 0, 0, 3'b000, 5'd0, 5'd0, 16'd0});
    vecs.push_back('{1, LW4,     0, 0, 1, 1, 1, 3'b010, 5'd0, 5'd4, 16'd0});
    vecs.push_back('{1, ADD5_46, 0, 1, 0, 0, 0, 3'b000, 5'd5, 5'd6, 16'd1});
    vecs.push_back('{1, ADD5_46, 0, 0, 1, 1, 0, 3'b100, 5'd5, 5'd6, 16'd1});
    vecs.push_back('{1, LW0,     0, 0, 1, 1, 1, 3'b010, 5'd0, 5'd0, 16'd1});
    vecs.push_back('{1, ADD5_06, 0, 0, 1, 1, 0, 3'b100, 5'd5, 5'd6, 16'd1});
    vecs.push_back('{1, LW4,     0, 0, 1, 1, 1, 3'b010, 5'd0, 5'd4, 16'd1});
    vecs.push_back('{1, SW4,     0, 1, 0, 0, 0, 3'b000, 5'd0, 5'd4, 16'd2});
    vecs.push_back('{1, SW4,     0, 0, 1, 0, 0, 3'b010, 5'd0, 5'd4, 16'd2});
    vecs.push_back('{1, LW4,     0, 0, 1, 1, 1, 3'b010, 5'd0, 5'd4, 16'd2});
    vecs.push_back('{1, ADD5_46, 1, 0, 0, 0, 0, 3'b000, 5'd5, 5'd6, 16'd2});
    vecs.push_back('{1, LW4,     0, 0, 1, 1, 1, 3'b010, 5'd0, 5'd4, 16'd2});
    vecs.push_back('{1, ADD5_64, 0, 1, 0, 0, 0, 3'b000, 5'd5, 5'd4, 16'd3});
    vecs.push_back('{1, LW4,     0, 0, 1, 1, 1, 3'b010, 5'd0, 5'd4, 16'd3});
    vecs.push_back('{1, ADDI4,   0, 0, 1, 1, 0, 3'b010, 5'd0, 5'd4, 16'd3});
    vecs.push_back('{1, LW4,     0, 0, 1, 1, 1, 3'b010, 5'd0, 5'd4, 16'd3});
    vecs.push_back('{0, ADD5_46, 0, 0, 0, 0, 0, 3'b000, 5'd5, 5'd6, 16'd3});

    drive(0, 32'd0, 0);
    #2;
    chk("reset_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("reset_rw", {31'd0, ex_RegWrite_o}, 32'd0);
    chk("reset_cnt", {16'd0, stall_cnt_o}, 32'd0);
    chk("reset_rsdata", ex_rs_data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].vld, vecs[i].ins, vecs[i].fl);
      exp_rsd = rs_data_i;
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_nohz_stall", i), {31'd0, n_stall}, 32'd0);
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid_o}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_regwrite", i), {31'd0, ex_RegWrite_o}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_memread", i), {31'd0, ex_MemRead_o}, {31'd0, vecs[i].e_mr});
      chk($sformatf("v%0d_aluop", i), {29'd0, ex_ALU_op_o}, {29'd0, vecs[i].e_aluop});
      chk($sformatf("v%0d_rd", i), {27'd0, ex_rd_o}, {27'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_rt", i), {27'd0, ex_rt_o}, {27'd0, vecs[i].e_rt});
      chk($sformatf("v%0d_cnt", i), {16'd0, stall_cnt_o}, {16'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d_rsdata", i), ex_rs_data_o, exp_rsd);
      sat_exp = (vecs[i].e_cnt > 16'd3) ? 16'd3 : vecs[i].e_cnt;
      chk($sformatf("v%0d_sat_cnt", i), {30'd0, s_cnt}, {16'd0, sat_exp});
    end

    // Reset asserted while a load-use stall is pending: everything clears without an edge.
    @(negedge clk_i); drive(1, LW4, 0);
    @(negedge clk_i); drive(1, ADD5_46, 0);
    #1;
    chk("rst_mid_stall_pre", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("rst_mid_memread", {31'd0, ex_MemRead_o}, 32'd0);
    chk("rst_mid_rt", {27'd0, ex_rt_o}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_mid_cnt", {16'd0, stall_cnt_o}, 32'd0);
    chk("rst_mid_sat_cnt", {30'd0, s_cnt}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Five forced load-use stalls: wide counter reaches 5, 2-bit counter pins at 3.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i); drive(1, LW4, 0);
      @(negedge clk_i); drive(1, ADD5_46, 0);
      #1;
      chk($sformatf("sat%0d_stall", k), {31'd0, stall_o}, 32'd1);
      @(posedge clk_i);
      #1;
      if (k == 2) chk("sat_at3", {30'd0, s_cnt}, 32'd3);
    end
    chk("sat_wide_cnt", {16'd0, stall_cnt_o}, 32'd5);
    chk("sat_narrow_cnt", {30'd0, s_cnt}, 32'd3);
    chk("nohz_cnt", {16'd0, n_cnt}, 32'd0);

    @(negedge clk_i); drive(0, 32'd0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
